// File: rtl/button_autorepeat_pkg.sv
// Shared types and default timing for the button autorepeat conditioner.
// Defaults assume a 50 MHz system clock.
package button_autorepeat_pkg;

   localparam int CLK_HZ               = 50_000_000;
   localparam int DEF_DEBOUNCE_CYC     = 1_000_000;
   localparam int DEF_HOLD_CYC         = 25_000_000;
   localparam int DEF_REPEAT_CYC       = 5_000_000;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_REPEAT = 2'd2,
      S_LOCK   = 2'd3
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_autorepeat_sync_debounce.sv
// Two-flop synchronizer plus stable-run counter producing a debounced pressed level.
// o_level_nxt exposes the value o_level takes at the coming edge so the FSM can react in the same cycle.
module button_autorepeat_sync_debounce
   import button_autorepeat_pkg::*;
#(
   parameter int BTN_ACTIVE_LOW = 1,
   parameter int DEBOUNCE_CYC   = DEF_DEBOUNCE_CYC
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn_raw,
   output logic o_level,
   output logic o_level_nxt
);

   localparam int            CNT_W     = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic          RAW_IDLE  = (BTN_ACTIVE_LOW != 0);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic [CNT_W-1:0] r_cnt;
   logic             w_pressed;
   logic             w_differs;
   logic             w_toggle;

   assign w_pressed   = r_sync2 ^ RAW_IDLE;
   assign w_differs   = (w_pressed != r_level);
   assign w_toggle    = w_differs && (r_cnt == CNT_LAST);
   assign o_level     = r_level;
   assign o_level_nxt = w_toggle ? ~r_level : r_level;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1 <= RAW_IDLE;
         r_sync2 <= RAW_IDLE;
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_btn_raw;
         r_sync2 <= r_sync1;
         // The run counter only advances while the synced input disagrees with the accepted level.
         if (!w_differs) begin
            r_cnt <= '0;
         end else if (w_toggle) begin
            r_level <= ~r_level;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/button_autorepeat.sv
// Push-button conditioner: debounced level, press pulse, then hold-to-repeat pulse stream.
// state    | meaning
// S_IDLE   | released, waiting for a debounced press
// S_WAIT   | pressed, first pulse issued, timing the hold delay
// S_REPEAT | auto-repeat phase, pulse every REPEAT_CYC cycles
// S_LOCK   | pressed but pulses blocked until release
module button_autorepeat
   import button_autorepeat_pkg::*;
#(
   parameter int BTN_ACTIVE_LOW = 1,
   parameter int DEBOUNCE_CYC   = DEF_DEBOUNCE_CYC,
   parameter int HOLD_CYC       = DEF_HOLD_CYC,
   parameter int REPEAT_CYC     = DEF_REPEAT_CYC,
   parameter int REPEAT_EN      = 1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn_raw,
   input  logic i_enable,
   output logic o_btn_level,
   output logic o_btn_pulse,
   output logic o_btn_held
);

   generate
      if (DEBOUNCE_CYC < 1 || HOLD_CYC < 1 || REPEAT_CYC < 2) begin : g_bad_params
         $error("button_autorepeat: DEBOUNCE_CYC/HOLD_CYC must be >=1 and REPEAT_CYC >=2");
      end
   endgenerate

   localparam int               TMR_W     = $clog2(max_int(HOLD_CYC, REPEAT_CYC));
   localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYC - 1);
   localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYC - 1);

   state_t           r_state;
   logic [TMR_W-1:0] r_tmr;
   logic             r_pulse;
   logic             r_held;
   logic             w_level;
   logic             w_level_nxt;
   logic             w_rise;

   button_autorepeat_sync_debounce #(
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW),
      .DEBOUNCE_CYC   (DEBOUNCE_CYC)
   ) u_sync_debounce (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_btn_raw   (i_btn_raw),
      .o_level     (w_level),
      .o_level_nxt (w_level_nxt)
   );

   assign w_rise      = w_level_nxt & ~w_level;
   assign o_btn_level = w_level;
   assign o_btn_pulse = r_pulse;
   assign o_btn_held  = r_held;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_tmr   <= '0;
         r_pulse <= 1'b0;
         r_held  <= 1'b0;
      end else begin
         r_pulse <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_held <= 1'b0;
               r_tmr  <= '0;
               if (w_rise) begin
                  if (i_enable) begin
                     r_pulse <= 1'b1;
                     r_state <= S_WAIT;
                  end else begin
                     r_state <= S_LOCK;
                  end
               end
            end
            S_WAIT: begin
               // Release is checked first so it beats a coincident timer expiry.
               if (!w_level_nxt) begin
                  r_state <= S_IDLE;
                  r_tmr   <= '0;
               end else if (!i_enable) begin
                  r_state <= S_LOCK;
                  r_tmr   <= '0;
               end else if (r_tmr == HOLD_LAST) begin
                  if (REPEAT_EN != 0) begin
                     r_pulse <= 1'b1;
                     r_tmr   <= '0;
                     r_state <= S_REPEAT;
                  end
               end else begin
                  r_tmr <= r_tmr + 1'b1;
               end
            end
            S_REPEAT: begin
               if (!w_level_nxt) begin
                  r_state <= S_IDLE;
                  r_held  <= 1'b0;
                  r_tmr   <= '0;
               end else if (!i_enable) begin
                  r_state <= S_LOCK;
                  r_held  <= 1'b0;
                  r_tmr   <= '0;
               end else begin
                  r_held <= 1'b1;
                  if (r_tmr == REP_LAST) begin
                     r_pulse <= 1'b1;
                     r_tmr   <= '0;
                  end else begin
                     r_tmr <= r_tmr + 1'b1;
                  end
               end
            end
            S_LOCK: begin
               r_held <= 1'b0;
               r_tmr  <= '0;
               if (!w_level_nxt) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_held  <= 1'b0;
               r_tmr   <= '0;
            end
         endcase
      end
   end

endmodule
